asg_pulse_decoder: RTL and testbench

Receive-side counterpart of the azimuth signal generator. After each radar trigger it samples a single-bit signal on every microsecond strobe for one SIZE-tick sweep. It converts high runs into (start tick, length) pulse records and queues them in a small FIFO for downstream logic or AXI readout over a valid/ready handshake. It is used as an in-fabric loopback checker for generated azimuth/target patterns and as a capture block for external radar video gating.

---
 rtl/asg_pkg.sv | 28 ++
 rtl/asg_record_fifo.sv | 54 +++++
 rtl/asg_pulse_decoder.sv | 145 ++++++++++++++
 tb/tb_asg_pulse_decoder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asg_pkg.sv
// Shared definitions for the azimuth signal generator and its pulse decoder.
// Records are packed {trunc, len, start}, with start in the low bits.
package asg_pkg;

  localparam int DEF_SIZE = 3200;

  function automatic int cnt_w_for(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic int rec_w(input int cw);
    return 2 * cw + 1;
  endfunction

  localparam int DEF_CNT_W = cnt_w_for(DEF_SIZE);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 trunc;
    logic [DEF_CNT_W-1:0] len;
    logic [DEF_CNT_W-1:0] start;
  } pulse_rec_t;

endpackage

// File: rtl/asg_record_fifo.sv
// Show-ahead record queue: the head is visible whenever not empty.
// A push into a full queue is accepted only if a pop frees a slot.
module asg_record_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P1 = AW'(1);
  localparam logic [AW:0]   C1 = (AW+1)'(1);
  localparam logic [AW:0]   CF = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CF);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P1;
      if (do_pop)  rd_ptr <= rd_ptr + P1;
      if (do_push && !do_pop)
        count <= count + C1;
      else if (do_pop && !do_push)
        count <= count - C1;
    end
  end

endmodule

// File: rtl/asg_pulse_decoder.sv
// Sweep sampler: turns high runs of SIG_IN into {start, len, trunc}
// records queued for a valid/ready consumer.
module asg_pulse_decoder
  import asg_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int CNT_W      = cnt_w_for(SIZE),
  parameter int FIFO_DEPTH = 8
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  input  logic             EN,
  input  logic             TRIG,
  input  logic             CLK_PE,
  input  logic             SIG_IN,
  output logic             PULSE_VALID,
  input  logic             PULSE_READY,
  output logic [CNT_W-1:0] PULSE_START,
  output logic [CNT_W-1:0] PULSE_LEN,
  output logic             PULSE_TRUNC,
  output logic             SWEEP_DONE,
  output logic             ACTIVE,
  output logic             OVERFLOW
);

  localparam int RW = rec_w(CNT_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] SZ   = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] tick;
  logic [CNT_W-1:0] tick_nx;
  logic [CNT_W-1:0] start;
  logic [CNT_W-1:0] start_nx;
  logic [CNT_W-1:0] last_st;
  logic             prev;
  logic             prev_nx;
  logic             done;
  logic             done_nx;
  logic             ovf;
  logic             trig_ok;
  logic             push;
  logic [RW-1:0]    rec;
  logic [RW-1:0]    head;
  logic             pop;
  logic             full;
  logic             empty;

  assign trig_ok = TRIG & EN;
  // A pulse rising on the last tick starts there.
  assign last_st = prev ? start : tick;

  always_comb begin
    state_nx = state;
    tick_nx  = tick;
    start_nx = start;
    prev_nx  = prev;
    done_nx  = 1'b0;
    push     = 1'b0;
    rec      = '0;
    unique case (state)
      S_IDLE: begin
        if (trig_ok) begin
          state_nx = S_RUN;
          tick_nx  = '0;
          prev_nx  = 1'b0;
        end
      end
      S_RUN: begin
        if (trig_ok) begin
          if (prev) begin
            push = 1'b1;
            rec  = {1'b1, tick - start, start};
          end
          tick_nx = '0;
          prev_nx = 1'b0;
        end else if (CLK_PE) begin
          prev_nx = SIG_IN;
          tick_nx = tick + ONE;
          if (SIG_IN && !prev) start_nx = tick;
          if (!SIG_IN && prev) begin
            push = 1'b1;
            rec  = {1'b0, tick - start, start};
          end
          if (tick == LAST) begin
            if (SIG_IN) begin
              push = 1'b1;
              rec  = {1'b1, SZ - last_st, last_st};
            end
            state_nx = S_IDLE;
            done_nx  = 1'b1;
            tick_nx  = '0;
            prev_nx  = 1'b0;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state <= S_IDLE;
      tick  <= '0;
      start <= '0;
      prev  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      tick  <= tick_nx;
      start <= start_nx;
      prev  <= prev_nx;
      done  <= done_nx;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  assign pop = PULSE_VALID & PULSE_READY;

  asg_record_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (SYS_CLK),
    .rst   (SYS_RST),
    .push  (push),
    .wdata (rec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign PULSE_VALID = ~empty;
  assign PULSE_START = head[CNT_W-1:0];
  assign PULSE_LEN   = head[2*CNT_W-1:CNT_W];
  assign PULSE_TRUNC = head[2*CNT_W];
  assign SWEEP_DONE  = done;
  assign ACTIVE      = (state == S_RUN);
  assign OVERFLOW    = ovf;

endmodule

// File: tb/tb_asg_pulse_decoder.sv
// Bench for asg_pulse_decoder: sample-list reference model checked every
// cycle, plus literal record expectations for the directed sweeps.
module tb_asg_pulse_decoder;
  import asg_pkg::*;

  localparam int SIZE  = DEF_SIZE;
  localparam int CW    = DEF_CNT_W;
  localparam int DEPTH = 8;

  logic          SYS_CLK = 1'b0;
  logic          SYS_RST = 1'b1;
  logic          EN = 1'b0;
  logic          TRIG = 1'b0;
  logic          CLK_PE = 1'b0;
  logic          SIG_IN = 1'b0;
  logic          PULSE_READY;
  logic          PULSE_VALID;
  logic [CW-1:0] PULSE_START;
  logic [CW-1:0] PULSE_LEN;
  logic          PULSE_TRUNC;
  logic          SWEEP_DONE;
  logic          ACTIVE;
  logic          OVERFLOW;

  asg_pulse_decoder #(
    .SIZE       (SIZE),
    .CNT_W      (CW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .SYS_CLK     (SYS_CLK),
    .SYS_RST     (SYS_RST),
    .EN          (EN),
    .TRIG        (TRIG),
    .CLK_PE      (CLK_PE),
    .SIG_IN      (SIG_IN),
    .PULSE_VALID (PULSE_VALID),
    .PULSE_READY (PULSE_READY),
    .PULSE_START (PULSE_START),
    .PULSE_LEN   (PULSE_LEN),
    .PULSE_TRUNC (PULSE_TRUNC),
    .SWEEP_DONE  (SWEEP_DONE),
    .ACTIVE      (ACTIVE),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  // 0 = hold low, 1 = hold high, 2 = random each cycle
  int ready_mode = 1;
  always @(negedge SYS_CLK)
    PULSE_READY = (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);

  // Reference model: the sweep is a list of sampled bits, runs are
  // recovered by scanning it.
  bit         m_active = 0;
  bit         m_done = 0;
  bit         m_ovf = 0;
  bit         smp[$];
  pulse_rec_t exp_q[$];
  pulse_rec_t m_r;
  bit         m_have;
  bit         m_pop;
  int         n;

  function automatic pulse_rec_t run_rec(input int end_x, input bit tr);
    pulse_rec_t r;
    int s;
    s = end_x - 1;
    while (s > 0 && smp[s-1]) s--;
    r.start = CW'(s);
    r.len   = CW'(end_x - s);
    r.trunc = tr;
    return r;
  endfunction

  always @(posedge SYS_CLK) begin
    m_have = 0;
    m_done = 0;
    if (SYS_RST) begin
      m_active = 0;
      m_ovf = 0;
      smp.delete();
      exp_q.delete();
    end else begin
      m_pop = (exp_q.size() != 0) && PULSE_READY;
      if (TRIG && EN) begin
        if (m_active && smp.size() > 0 && smp[$]) begin
          m_r = run_rec(smp.size(), 1'b1);
          m_have = 1;
        end
        m_active = 1;
        smp.delete();
      end else if (m_active && CLK_PE) begin
        smp.push_back(SIG_IN);
        n = smp.size();
        if (n >= 2 && !smp[n-1] && smp[n-2]) begin
          m_r = run_rec(n - 1, 1'b0);
          m_have = 1;
        end
        if (n == SIZE) begin
          if (smp[n-1]) begin
            m_r = run_rec(n, 1'b1);
            m_have = 1;
          end
          m_active = 0;
          m_done = 1;
          smp.delete();
        end
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_have) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_r);
        else m_ovf = 1;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge SYS_CLK) begin
    if (chk_en) begin
      chk("valid", PULSE_VALID, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("start", PULSE_START, exp_q[0].start);
        chk("len", PULSE_LEN, exp_q[0].len);
        chk("trunc", PULSE_TRUNC, exp_q[0].trunc);
      end
      chk("active", ACTIVE, m_active);
      chk("sweep_done", SWEEP_DONE, m_done);
      chk("overflow", OVERFLOW, m_ovf);
    end
  end

  pulse_rec_t got_q[$];
  int done_cnt = 0;
  always @(posedge SYS_CLK)
    if (!SYS_RST && PULSE_VALID && PULSE_READY)
      got_q.push_back({PULSE_TRUNC, PULSE_LEN, PULSE_START});
  always @(negedge SYS_CLK)
    if (SWEEP_DONE === 1'b1) done_cnt++;

  int mode = 0;
  bit rnd_sig[SIZE];

  function automatic bit sig_at(input int t);
    case (mode)
      0: return t >= 100 && (t - 100) % 400 < 3;
      1: return t <= 4 || t >= 3195;
      2: return t >= 1000;
      3: return t >= 10 && t < 200 && (t - 10) % 20 < 2;
      4: return rnd_sig[t];
      5: return 1'b1;
      6: return t == 0;
      7: return t >= 100 && t < 1000 && (t - 100) % 400 < 3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick(input int t, input int gap);
    @(negedge SYS_CLK);
    CLK_PE = 1'b1;
    SIG_IN = sig_at(t);
    @(negedge SYS_CLK);
    CLK_PE = 1'b0;
    SIG_IN = 1'($urandom);
    repeat (gap) @(negedge SYS_CLK);
  endtask

  task automatic ticks(input int from, input int to, input int gmax);
    for (int t = from; t <= to; t++)
      tick(t, gmax > 0 ? int'($urandom_range(gmax, 0)) : 0);
  endtask

  task automatic trigger(input bit en);
    @(negedge SYS_CLK);
    TRIG = 1'b1;
    EN = en;
    @(negedge SYS_CLK);
    TRIG = 1'b0;
    EN = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge SYS_CLK);
    SYS_RST = 1'b1;
    @(negedge SYS_CLK);
    SYS_RST = 1'b0;
  endtask

  task automatic expect_rec(input int i, input int s, input int l,
                            input int tr);
    checks++;
    if (got_q.size() <= i) begin
      failures++;
      $display("FAIL rec%0d: got only %0d records", i, got_q.size());
    end else begin
      chk($sformatf("rec%0d.start", i), got_q[i].start, s);
      chk($sformatf("rec%0d.len", i), got_q[i].len, l);
      chk($sformatf("rec%0d.trunc", i), got_q[i].trunc, tr);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".valid"}, PULSE_VALID, 0);
    chk({tag, ".active"}, ACTIVE, 0);
    chk({tag, ".done"}, SWEEP_DONE, 0);
    chk({tag, ".ovf"}, OVERFLOW, 0);
    chk({tag, ".start"}, PULSE_START, 0);
    chk({tag, ".len"}, PULSE_LEN, 0);
    chk({tag, ".trunc"}, PULSE_TRUNC, 0);
  endtask

  bit lvl;

  initial begin
    repeat (3) @(negedge SYS_CLK);
    chk_reset_outputs("reset");
    SYS_RST = 1'b0;
    chk_en = 1;

    // eight short pulses over a full sweep
    mode = 0;
    trigger(1);
    ticks(0, SIZE - 1, 0);
    repeat (3) @(negedge SYS_CLK);
    chk("t1.count", got_q.size(), 8);
    for (int k = 0; k < 8; k++) expect_rec(k, 100 + 400 * k, 3, 0);
    chk("t1.done_cnt", done_cnt, 1);
    chk("t1.active", ACTIVE, 0);

    // pulses touching both sweep boundaries
    got_q.delete();
    mode = 1;
    trigger(1);
    ticks(0, SIZE - 1, 0);
    repeat (3) @(negedge SYS_CLK);
    chk("t2.count", got_q.size(), 2);
    expect_rec(0, 0, 5, 0);
    expect_rec(1, 3195, 5, 1);
    chk("t2.done_cnt", done_cnt, 2);

    // re-trigger with an open pulse, then a sweep high throughout
    got_q.delete();
    mode = 2;
    trigger(1);
    ticks(0, 1009, 0);
    trigger(1);
    mode = 5;
    ticks(0, SIZE - 1, 0);
    repeat (3) @(negedge SYS_CLK);
    chk("t3.count", got_q.size(), 2);
    expect_rec(0, 1000, 10, 1);
    expect_rec(1, 0, SIZE, 1);
    chk("t3.done_cnt", done_cnt, 3);

    // ten pulses into an eight-deep queue with the consumer stalled
    got_q.delete();
    ready_mode = 0;
    mode = 3;
    trigger(1);
    ticks(0, 199, 0);
    repeat (3) @(negedge SYS_CLK);
    chk("t4.overflow", OVERFLOW, 1);
    chk("t4.valid", PULSE_VALID, 1);
    chk("t4.none", got_q.size(), 0);
    ready_mode = 1;
    repeat (12) @(negedge SYS_CLK);
    chk("t4.count", got_q.size(), 8);
    for (int k = 0; k < 8; k++) expect_rec(k, 10 + 20 * k, 2, 0);
    chk("t4.overflow_sticky", OVERFLOW, 1);
    do_reset();
    chk("t4.ovf_cleared", OVERFLOW, 0);

    // disabled trigger, then trigger coincident with a strobe
    got_q.delete();
    trigger(0);
    repeat (4) @(negedge SYS_CLK);
    chk("t5.idle", ACTIVE, 0);
    chk("t5.none", got_q.size(), 0);
    mode = 5;
    trigger(1);
    ticks(0, 4, 0);
    @(negedge SYS_CLK);
    TRIG = 1'b1;
    EN = 1'b1;
    CLK_PE = 1'b1;
    SIG_IN = 1'b1;
    @(negedge SYS_CLK);
    TRIG = 1'b0;
    CLK_PE = 1'b0;
    mode = 6;
    ticks(0, 3, 0);
    repeat (3) @(negedge SYS_CLK);
    chk("t5.count", got_q.size(), 2);
    expect_rec(0, 0, 5, 1);
    expect_rec(1, 0, 1, 0);
    do_reset();

    // reset mid-sweep with records queued
    got_q.delete();
    ready_mode = 0;
    mode = 7;
    trigger(1);
    ticks(0, 600, 0);
    trigger(0);
    ticks(601, 1500, 0);
    chk("t6.active", ACTIVE, 1);
    chk("t6.valid", PULSE_VALID, 1);
    @(negedge SYS_CLK);
    SYS_RST = 1'b1;
    @(negedge SYS_CLK);
    SYS_RST = 1'b0;
    chk_reset_outputs("t6");
    ready_mode = 1;
    repeat (5) @(negedge SYS_CLK);
    chk("t6.flushed", got_q.size(), 0);

    // random signal, random consumer, one random re-trigger
    ready_mode = 2;
    mode = 4;
    for (int sw = 0; sw < 3; sw++) begin
      lvl = 0;
      for (int t = 0; t < SIZE; t++) begin
        if ($urandom_range(7, 0) == 0) lvl = ~lvl;
        rnd_sig[t] = lvl;
      end
      trigger(1);
      if (sw == 1) begin
        ticks(0, int'($urandom_range(2500, 500)), 1);
        trigger(1);
      end
      ticks(0, SIZE - 1, 1);
      repeat (4) @(negedge SYS_CLK);
    end
    ready_mode = 1;
    repeat (20) @(negedge SYS_CLK);
    chk("end.drained", PULSE_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
